// File: rtl/vga_fb_scheduler_pkg.sv
// Shared types and constants for the VGA frame-buffer port scheduler.
//   px_fmt_e     stored pixel formats
//   pixel_depth  bits per stored pixel for a given format
//   FrameSize    default frame size in pixels; fb_addr_t is sized from it
//   access_e     per-cycle decision for the single RAM port
package vga_fb_scheduler_pkg;

    typedef enum logic [0:0] {
        FmtRgb332,
        FmtRgb12
    } px_fmt_e;

    localparam int unsigned DefPixelWidth  = 640;
    localparam int unsigned DefPixelHeight = 480;
    localparam int unsigned FrameSize      = DefPixelWidth * DefPixelHeight;
    localparam int unsigned AddrW          = $clog2(FrameSize);

    typedef logic [AddrW-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        AccIdle,
        AccRead,
        AccWrite
    } access_e;

    function automatic int unsigned pixel_depth(input px_fmt_e fmt);
        unique case (fmt)
            FmtRgb332: return 8;
            FmtRgb12:  return 12;
            default:   return 8;
        endcase
    endfunction

endpackage

// File: rtl/vga_fb_scheduler_px_fifo.sv
// Scanout prefetch FIFO: synchronous, show-ahead head, occupancy count, flush.
//   pxclk, rst_n  clock / synchronous active-low reset
//   flush         empties the FIFO; push and pop are ignored that cycle
//   push, wdata   write to tail (dropped only if full with no pop)
//   pop           advance head (ignored when empty)
//   head          current head entry, 0 when empty
//   count         number of stored entries, 0..DEPTH
//   empty         count == 0
module vga_fb_scheduler_px_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   pxclk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok, full;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge pxclk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge pxclk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Owns the single frame-buffer RAM port. Scanout prefetch keeps a pixel FIFO ahead of the
// display; pixel writers get the leftover slots round-robin, but scanout preempts them whenever
// the effective level drops below LOW_WATER.
//   pxclk, rst_n        clock / synchronous active-low reset
//   frame_start         flush FIFO, restart fetch at address 0
//   px_pop              consumer takes px_data
//   px_data, px_avail   FIFO head (0 when empty) / FIFO non-empty
//   underflow           sticky pop-while-empty flag, cleared by underflow_clr
//   wr_req/addr/data    packed per-requester write requests
//   wr_gnt              one-hot grant; the write is issued in the grant cycle
//   ram_en/we/addr/wdata  RAM command; ram_rdata valid one cycle after a read
module vga_fb_scheduler
    import vga_fb_scheduler_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = DefPixelWidth,
    parameter int unsigned PIXEL_HEIGHT = DefPixelHeight,
    parameter int unsigned PIXEL_DEPTH  = pixel_depth(FmtRgb332),
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned LOW_WATER    = 4,
    localparam int unsigned ADDR_W      = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT)
) (
    input  logic                         pxclk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic                         px_pop,
    output logic [PIXEL_DEPTH-1:0]       px_data,
    output logic                         px_avail,
    output logic                         underflow,
    input  logic                         underflow_clr,
    input  logic [N_REQ-1:0]             wr_req,
    input  logic [N_REQ*ADDR_W-1:0]      wr_addr,
    input  logic [N_REQ*PIXEL_DEPTH-1:0] wr_data,
    output logic [N_REQ-1:0]             wr_gnt,
    output logic                         ram_en,
    output logic                         ram_we,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [PIXEL_DEPTH-1:0]       ram_wdata,
    input  logic [PIXEL_DEPTH-1:0]       ram_rdata
);
    localparam int unsigned FRAME = PIXEL_WIDTH * PIXEL_HEIGHT;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LVL_W = CNT_W + 1;
    localparam int unsigned RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

    logic [ADDR_W-1:0]      fetch_addr_q, fetch_addr_d;
    logic                   fetch_done_q, fetch_done_d;
    logic [RR_W-1:0]        rr_q, rr_d;
    logic                   inflight_q, inflight_d;
    logic                   underflow_q, underflow_d;

    logic [CNT_W-1:0]       fifo_count;
    logic [PIXEL_DEPTH-1:0] fifo_head;
    logic                   fifo_empty;
    logic                   fifo_push, fifo_pop;

    logic [LVL_W-1:0]       lvl;
    logic                   fetch_ok, starving;
    logic                   any_req, found;
    int unsigned            rr_idx;
    logic [RR_W-1:0]        gnt_idx;
    access_e                acc;

    // A read issued last cycle is already committed to a FIFO slot.
    assign lvl      = LVL_W'(fifo_count) + LVL_W'(inflight_q);
    assign fetch_ok = rst_n && !frame_start && !fetch_done_q && (lvl < LVL_W'(FIFO_DEPTH));
    assign starving = (lvl < LVL_W'(LOW_WATER));
    assign any_req  = rst_n && (|wr_req);

    // First requester at or after the round-robin pointer.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rr_idx = (32'(rr_q) + i) % N_REQ;
            if (!found && wr_req[rr_idx]) begin
                found   = 1'b1;
                gnt_idx = rr_idx[RR_W-1:0];
            end
        end
    end

    always_comb begin
        if (fetch_ok && starving) begin
            acc = AccRead;
        end else if (any_req) begin
            acc = AccWrite;
        end else if (fetch_ok) begin
            acc = AccRead;
        end else begin
            acc = AccIdle;
        end
    end

    // RAM command and grant outputs.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        wr_gnt    = '0;
        unique case (acc)
            AccRead: begin
                ram_en   = 1'b1;
                ram_addr = fetch_addr_q;
            end
            AccWrite: begin
                ram_en          = 1'b1;
                ram_we          = 1'b1;
                ram_addr        = wr_addr[gnt_idx*ADDR_W +: ADDR_W];
                ram_wdata       = wr_data[gnt_idx*PIXEL_DEPTH +: PIXEL_DEPTH];
                wr_gnt[gnt_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state logic. frame_start discards the read returning this cycle and any pop.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        fetch_done_d = fetch_done_q;
        rr_d         = rr_q;
        inflight_d   = (acc == AccRead);

        if (frame_start) begin
            fetch_addr_d = '0;
            fetch_done_d = 1'b0;
        end else if (acc == AccRead) begin
            if (fetch_addr_q == LAST_ADDR) begin
                fetch_done_d = 1'b1;
            end else begin
                fetch_addr_d = fetch_addr_q + 1'b1;
            end
        end

        if (acc == AccWrite) begin
            rr_d = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end

        // A new underflow beats a same-cycle clear.
        if (px_pop && fifo_empty && !frame_start) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    assign fifo_push = inflight_q && !frame_start;
    assign fifo_pop  = px_pop && !frame_start;

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            fetch_addr_q <= '0;
            fetch_done_q <= 1'b0;
            rr_q         <= '0;
            inflight_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            fetch_done_q <= fetch_done_d;
            rr_q         <= rr_d;
            inflight_q   <= inflight_d;
            underflow_q  <= underflow_d;
        end
    end

    vga_fb_scheduler_px_fifo #(
        .WIDTH (PIXEL_DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_px_fifo (
        .pxclk (pxclk),
        .rst_n (rst_n),
        .flush (frame_start),
        .push  (fifo_push),
        .wdata (ram_rdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign px_data   = fifo_head;
    assign px_avail  = !fifo_empty;
    assign underflow = underflow_q;

endmodule
